// File: rtl/muldiv_iter_if.sv
// Command/result bundle between the CPU controller and the iterative mul/div unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hl_write;
  logic             sel_hl;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] dout;
  logic             ready;
  logic             div_zero;

  // Controller side: issues operations and HI/LO writes, reads results.
  modport master (
    output start, op, sign, a, b, cancel, hl_write, sel_hl, wdata,
    input  dout, ready, div_zero
  );

  // Unit side.
  modport slave (
    input  start, op, sign, a, b, cancel, hl_write, sel_hl, wdata,
    output dout, ready, div_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply / divide / multiply-accumulate unit with HI/LO registers.
// One shared 2*WIDTH work register holds either the shift-add product
// ({partial_hi, multiplier}) or the restoring-divide state ({rem, dividend}).
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_iter_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_MSUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [W2-1:0]    work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  // Operand magnitudes and signs taken at launch.
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             in_sa, in_sb;

  always_comb begin
    in_sa = bus.sign & bus.a[WIDTH-1];
    in_sb = bus.sign & bus.b[WIDTH-1];
    mag_a = in_sa ? ((~bus.a) + WIDTH'(1)) : bus.a;
    mag_b = in_sb ? ((~bus.b) + WIDTH'(1)) : bus.b;
  end

  // One shift-add step and one restoring-divide step on the work register.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;

  always_comb begin
    mul_sum   = {1'b0, work_q[W2-1:WIDTH]} + {1'b0, (work_q[0] ? ma_q : '0)};
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    div_trial = {work_q[W2-1:WIDTH], work_q[WIDTH-1]} - {1'b0, mb_q};
    div_rem   = div_trial[WIDTH] ? {work_q[W2-2:WIDTH], work_q[WIDTH-1]}
                                 : div_trial[WIDTH-1:0];
    div_next  = {div_rem, work_q[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Sign fix-up and result placement, consumed on the FIX edge.
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    acc_add;
  logic [W2-1:0]    acc_sub;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  always_comb begin
    prod_s  = (sa_q ^ sb_q) ? ((~work_q) + W2'(1)) : work_q;
    acc_add = {hi_q, lo_q} + prod_s;
    acc_sub = {hi_q, lo_q} - prod_s;
    quo_s   = (sa_q ^ sb_q) ? ((~work_q[WIDTH-1:0]) + WIDTH'(1)) : work_q[WIDTH-1:0];
    rem_s   = sa_q ? ((~work_q[W2-1:WIDTH]) + WIDTH'(1)) : work_q[W2-1:WIDTH];
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      a_raw_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      a_raw_q    <= a_raw_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_d       = dz_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    a_raw_d    = a_raw_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.hl_write) begin
          if (bus.sel_hl) hi_d = bus.wdata;
          else            lo_d = bus.wdata;
        end
        if (bus.start) begin
          state_d    = S_BUSY;
          op_d       = bus.op;
          sa_d       = in_sa;
          sb_d       = in_sb;
          dz_d       = (bus.op == OP_DIV) && (bus.b == '0);
          ma_d       = mag_a;
          mb_d       = mag_b;
          a_raw_d    = bus.a;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          // Divide starts from the dividend, multiply from the multiplier.
          work_d     = (bus.op == OP_DIV) ? {WIDTH'(0), mag_a} : {WIDTH'(0), mag_b};
        end
      end

      S_BUSY: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          work_d = (op_q == OP_DIV) ? div_next : mul_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          case (op_q)
            OP_MUL:  {hi_d, lo_d} = prod_s;
            OP_MADD: {hi_d, lo_d} = acc_add;
            OP_MSUB: {hi_d, lo_d} = acc_sub;
            default: begin
              if (dz_q) begin
                lo_d       = '1;
                hi_d       = a_raw_q;
                div_zero_d = 1'b1;
              end else begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dout     = bus.sel_hl ? hi_q : lo_q;
  assign bus.ready    = (state_q == S_IDLE);
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32 and WIDTH=8 instances).
module tb_muldiv_iter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  muldiv_iter_if #(.WIDTH(32)) bus32 ();
  muldiv_iter_if #(.WIDTH(8))  bus8  ();

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  muldiv_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read committed HI and LO of the 32-bit unit (called near a negedge).
  task automatic read_hl32(output logic [31:0] hi, output logic [31:0] lo);
    bus32.sel_hl = 1'b1;
    #1 hi = bus32.dout;
    bus32.sel_hl = 1'b0;
    #1 lo = bus32.dout;
  endtask

  // Launch one operation and count the negedges on which ready is low.
  task automatic run32(input logic [1:0] op, input logic sgn,
                       input logic [31:0] av, input logic [31:0] bv,
                       output int cyc);
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.sign  = sgn;
    bus32.a     = av;
    bus32.b     = bv;
    @(negedge clk);
    bus32.start = 1'b0;
    cyc = 0;
    while (bus32.ready !== 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus32.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus32.ready); end
    checks++;
    if (bus32.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", bus32.div_zero); end
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_mul();
    logic [31:0] hi, lo;
    int cyc;
    run32(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", cyc); end
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL smul_hi: got %h want ffffffff", hi); end
    checks++;
    if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL smul_lo: got %h want ffffffeb", lo); end
    run32(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umul_hi: got %h want fffffffe", hi); end
    checks++;
    if (lo !== 32'h0000_0001) begin errors++; $display("FAIL umul_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int cyc;
    run32(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_quo: got %h want fffffffd", lo); end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_rem: got %h want ffffffff", hi); end
    run32(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'h8000_0000) begin errors++; $display("FAIL min_div_quo: got %h want 80000000", lo); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL min_div_rem: got %h want 0", hi); end
    checks++;
    if (bus32.div_zero !== 1'b0) begin errors++; $display("FAIL min_div_flag: got %b want 0", bus32.div_zero); end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    int cyc;
    run32(2'b01, 1'b0, 32'd5, 32'd0, cyc);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL dz_latency: got %0d want 33", cyc); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    checks++;
    if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi: got %h want 5", hi); end
    checks++;
    if (bus32.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_set: got %b want 1", bus32.div_zero); end
    // Next accepted start clears the flag immediately.
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.sign = 1'b0;
    bus32.a = 32'd2; bus32.b = 32'd3;
    @(negedge clk);
    bus32.start = 1'b0;
    checks++;
    if (bus32.div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear: got %b want 0", bus32.div_zero); end
    cyc = 0;
    while (bus32.ready !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'd6) begin errors++; $display("FAIL dz_followup_lo: got %h want 6", lo); end
  endtask

  task automatic test_accumulate();
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk);
    bus32.hl_write = 1'b1; bus32.sel_hl = 1'b0; bus32.wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus32.sel_hl = 1'b1; bus32.wdata = 32'h0;
    @(negedge clk);
    bus32.hl_write = 1'b0;
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL preload_lo: got %h want ffffffff", lo); end
    run32(2'b10, 1'b0, 32'd1, 32'd1, cyc);
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'd1) begin errors++; $display("FAIL madd_hi: got %h want 1", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL madd_lo: got %h want 0", lo); end
    run32(2'b11, 1'b1, 32'd2, 32'd3, cyc);
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL msub_hi: got %h want 0", hi); end
    checks++;
    if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL msub_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_start_with_write();
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = 2'b10; bus32.sign = 1'b0;
    bus32.a = 32'd2; bus32.b = 32'd3;
    bus32.hl_write = 1'b1; bus32.sel_hl = 1'b0; bus32.wdata = 32'd10;
    @(negedge clk);
    bus32.start = 1'b0; bus32.hl_write = 1'b0;
    cyc = 0;
    while (bus32.ready !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'd16) begin errors++; $display("FAIL start_write_lo: got %h want 10", lo); end
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL start_write_hi: got %h want 0", hi); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.sign = 1'b0;
    bus32.a = 32'd3; bus32.b = 32'd4;
    @(negedge clk);
    bus32.start = 1'b0;
    cyc = 0;
    while (bus32.ready !== 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 5) begin
        bus32.start = 1'b1; bus32.op = 2'b01; bus32.a = 32'd100; bus32.b = 32'd7;
        bus32.hl_write = 1'b1; bus32.sel_hl = 1'b1; bus32.wdata = 32'hDEAD;
      end else begin
        bus32.start = 1'b0; bus32.hl_write = 1'b0;
      end
      @(negedge clk);
    end
    bus32.start = 1'b0; bus32.hl_write = 1'b0;
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 33", cyc); end
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL busy_ignore_hi: got %h want 0", hi); end
    checks++;
    if (lo !== 32'd12) begin errors++; $display("FAIL busy_ignore_lo: got %h want c", lo); end
  endtask

  task automatic test_cancel();
    logic [31:0] hi, lo;
    int cyc;
    // Cancel in BUSY at cycle 10.
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.sign = 1'b0;
    bus32.a = 32'd5; bus32.b = 32'd5;
    @(negedge clk);
    bus32.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    bus32.cancel = 1'b1;
    @(negedge clk);
    bus32.cancel = 1'b0;
    checks++;
    if (bus32.ready !== 1'b1) begin errors++; $display("FAIL cancel_busy_ready: got %b want 1", bus32.ready); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL cancel_busy_hl: got %h_%h want 00000000_0000000c", hi, lo); end
    // Cancel in FIX beats completion.
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = 32'd6; bus32.b = 32'd6;
    @(negedge clk);
    bus32.start = 1'b0;
    cyc = 1;
    while (cyc < 33) begin @(negedge clk); cyc++; end
    checks++;
    if (bus32.ready !== 1'b0) begin errors++; $display("FAIL cancel_fix_pre_ready: got %b want 0", bus32.ready); end
    bus32.cancel = 1'b1;
    @(negedge clk);
    bus32.cancel = 1'b0;
    checks++;
    if (bus32.ready !== 1'b1) begin errors++; $display("FAIL cancel_fix_ready: got %b want 1", bus32.ready); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'd12) begin errors++; $display("FAIL cancel_fix_lo: got %h want c", lo); end
    // Cancel in IDLE does not block a start.
    @(negedge clk);
    bus32.start = 1'b1; bus32.cancel = 1'b1; bus32.a = 32'd2; bus32.b = 32'd2;
    @(negedge clk);
    bus32.start = 1'b0; bus32.cancel = 1'b0;
    checks++;
    if (bus32.ready !== 1'b0) begin errors++; $display("FAIL cancel_idle_start: got %b want 0", bus32.ready); end
    cyc = 0;
    while (bus32.ready !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    read_hl32(hi, lo);
    checks++;
    if (lo !== 32'd4) begin errors++; $display("FAIL cancel_idle_lo: got %h want 4", lo); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.sign = 1'b0;
    bus32.a = 32'hFFFF_FFFF; bus32.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus32.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus32.ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b want 1", bus32.ready); end
    read_hl32(hi, lo);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_mid_hl: got %h_%h want 0_0", hi, lo); end
  endtask

  task automatic test_width8();
    logic [7:0] hi, lo;
    int cyc;
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 2'b00; bus8.sign = 1'b0;
    bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 0;
    while (bus8.ready !== 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL w8_latency: got %0d want 9", cyc); end
    bus8.sel_hl = 1'b1;
    #1 hi = bus8.dout;
    bus8.sel_hl = 1'b0;
    #1 lo = bus8.dout;
    checks++;
    if (hi !== 8'hFE) begin errors++; $display("FAIL w8_hi: got %h want fe", hi); end
    checks++;
    if (lo !== 8'h01) begin errors++; $display("FAIL w8_lo: got %h want 01", lo); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.sign = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.cancel = 1'b0;
    bus32.hl_write = 1'b0; bus32.sel_hl = 1'b0; bus32.wdata = '0;
    bus8.start = 1'b0; bus8.op = 2'b00; bus8.sign = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.cancel = 1'b0;
    bus8.hl_write = 1'b0; bus8.sel_hl = 1'b0; bus8.wdata = '0;

    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_accumulate();
    test_start_with_write();
    test_busy_ignore();
    test_cancel();
    test_reset_mid();
    test_width8();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the multi-cycle CPU. It is the successor to the fixed 32-bit MulDiv.
- Adds configurable WIDTH, multiply-accumulate and multiply-subtract (MADD/MSUB), a deterministic divide-by-zero result with a flag, and abort (cancel).
- Sits beside the ALU. Operands come from the RFA/RFB latches. The read port feeds the ALU-output mux. The controller stalls on ready.

Parameters:
- WIDTH, 32, operand, HI and LO width (>=4, even).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch operation; accepted only when ready=1.
- op  in  2  00 MUL, 01 DIV, 10 MADD, 11 MSUB.
- sign  in  1  1 = signed (two's complement) operands, 0 = unsigned.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort the operation in flight.
- hl_write  in  1  MTHI/MTLO write strobe.
- sel_hl  in  1  1 = HI, 0 = LO; used for both write and read.
- wdata  in  WIDTH  MTHI/MTLO data.
- dout  out  WIDTH  sel_hl ? HI : LO, combinational from registers.
- ready  out  1  1 in IDLE.
- div_zero  out  1  sticky divide-by-zero flag.

Behaviour:
- Reset (any state, including mid-operation): state=IDLE, HI=LO=0, ready=1, div_zero=0, counter and internal registers 0.
- States: IDLE, BUSY, FIX.
- IDLE -> BUSY on an edge with start=1:
  - latch op and sign;
  - latch |a| and |b| (magnitudes only when sign=1);
  - latch sa=a[MSB]&sign and sb=b[MSB]&sign;
  - clear counter and partial result; clear div_zero.
- BUSY: one iteration per edge for exactly WIDTH edges, then -> FIX.
  - MUL/MADD/MSUB: shift-add on the 2*WIDTH unsigned product.
  - DIV: restoring divide, one quotient bit per edge.
- FIX: one edge, then -> IDLE. HI/LO are written on this edge.
- Latency: start at edge E0, HI/LO valid and ready=1 after edge E(WIDTH+1). With WIDTH=32 that is 33 cycles BUSY+FIX.
- Sign fix-up:
  - product negated if sa^sb;
  - quotient negated if sa^sb;
  - remainder negated if sa.
  - Magnitude arithmetic is WIDTH-bit unsigned, so |MIN| is representable.
- Result placement:
  - MUL: {HI,LO} = product.
  - DIV: LO = quotient, HI = remainder.
  - MADD: {HI,LO} = {HI,LO} + product, modulo 2^(2*WIDTH).
  - MSUB: {HI,LO} = {HI,LO} - product, modulo 2^(2*WIDTH).
- Signed MIN / -1: LO=MIN, HI=0, no flag.
- Divide by zero (b==0, detected at start):
  - still spends WIDTH+1 cycles;
  - result LO = all ones, HI = a (the original input, not the magnitude);
  - div_zero=1 from the FIX edge until the next accepted start or reset.
- hl_write:
  - honoured only when ready=1; writes wdata to HI (sel_hl=1) or LO (sel_hl=0);
  - ignored while BUSY or FIX.
- start while ready=0: ignored.
- start and hl_write in the same IDLE cycle: both take effect. MADD/MSUB accumulate into the HI/LO value present at the FIX edge, so the write is included.
- cancel:
  - in BUSY or FIX: next state IDLE, HI/LO/div_zero unchanged, ready=1 after that edge;
  - cancel wins over completion in FIX;
  - in IDLE: no effect; start is still accepted.
- dout is readable in every state and shows the committed HI/LO, never partial results.

Test Plan:
- WIDTH=32, signed MUL, a=0xFFFFFFFD, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; ready low for exactly 33 cycles.
- Unsigned MUL, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed DIV:
  - -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
- DIV a=5, b=0 -> LO=0xFFFFFFFF, HI=5, div_zero=1; next accepted start clears div_zero.
- Accumulate:
  - preload LO=0xFFFFFFFF, HI=0 via hl_write, then unsigned MADD 1*1 -> HI=1, LO=0;
  - then signed MSUB 2*3 -> {HI,LO}=0x00000000_FFFFFFFA.
- Control:
  - start and hl_write during BUSY are ignored;
  - cancel at cycle 10 -> ready=1 next cycle with HI/LO unchanged;
  - reset at cycle 5 -> HI=LO=0, ready=1;
  - WIDTH=8 regression: unsigned MUL 0xFF*0xFF -> HI=0xFE, LO=0x01 after 9 cycles.
